// File: rtl/spi_flash_responder.sv
// SPI mode-0 target emulating the read side of a W25Q16 serial flash.
// Answers JEDEC-ID (0x9F), read-status (0x05) and read-data (0x03) out of a
// small internal byte memory that a system-side load port fills.
// All SPI pins are oversampled in the clk domain through 2-flop synchronizers.
`timescale 1ns / 1ps

module spi_flash_responder #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned AW     = 8,
  parameter logic [7:0]  STATUS = 8'h00
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_spi_clk,
  input  logic          i_cs,
  input  logic          i_spi_mosi,
  output logic          o_spi_miso,
  input  logic          i_ld_en,
  input  logic [AW-1:0] i_ld_addr,
  input  logic [7:0]    i_ld_data,
  output logic          o_cmd_valid,
  output logic [7:0]    o_cmd_code,
  output logic          o_busy
);

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StData,
    StId,
    StStat,
    StIgnore
  } state_e;

  // Synchronizers and edge-detect history
  logic [1:0] r_sclk_sync;
  logic [1:0] r_cs_sync;
  logic [1:0] r_mosi_sync;
  logic       r_sclk_prev;
  logic       r_cs_prev;

  logic w_sclk;
  logic w_cs;
  logic w_mosi;
  logic w_rise;
  logic w_fall;
  logic w_cs_fall;
  logic w_cs_rise;

  // Protocol state
  state_e        r_state;
  state_e        w_state_next;
  logic [4:0]    r_bit_cnt;
  logic [4:0]    w_bit_cnt_next;
  logic [6:0]    r_cmd_shift;
  logic [6:0]    w_cmd_shift_next;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] w_addr_next;
  logic [1:0]    r_id_idx;
  logic [1:0]    w_id_idx_next;
  logic          r_miso;
  logic          w_miso_next;
  logic          r_cmd_valid;
  logic          w_cmd_valid_next;
  logic [7:0]    r_cmd_code;
  logic [7:0]    w_cmd_code_next;
  logic          r_busy;

  logic [7:0]    w_byte;
  logic [7:0]    w_tx_byte;
  logic          w_fetch;
  logic [AW-1:0] w_fetch_addr;

  // Memory
  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_mem_rdata;

  // Bring SPI pins into the clk domain and keep one cycle of history for edges
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sclk_sync <= 2'b00;
      r_cs_sync   <= 2'b11;
      r_mosi_sync <= 2'b00;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[0], i_spi_clk};
      r_cs_sync   <= {r_cs_sync[0], i_cs};
      r_mosi_sync <= {r_mosi_sync[0], i_spi_mosi};
      r_sclk_prev <= r_sclk_sync[1];
      r_cs_prev   <= r_cs_sync[1];
    end
  end

  assign w_sclk    = r_sclk_sync[1];
  assign w_cs      = r_cs_sync[1];
  assign w_mosi    = r_mosi_sync[1];
  assign w_rise    = w_sclk & ~r_sclk_prev;
  assign w_fall    = ~w_sclk & r_sclk_prev;
  assign w_cs_fall = r_cs_prev & ~w_cs;
  assign w_cs_rise = ~r_cs_prev & w_cs;

  // State and datapath registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_bit_cnt   <= 5'd0;
      r_cmd_shift <= 7'd0;
      r_addr      <= '0;
      r_id_idx    <= 2'd0;
      r_miso      <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd_code  <= 8'h00;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_cmd_shift <= w_cmd_shift_next;
      r_addr      <= w_addr_next;
      r_id_idx    <= w_id_idx_next;
      r_miso      <= w_miso_next;
      r_cmd_valid <= w_cmd_valid_next;
      r_cmd_code  <= w_cmd_code_next;
      r_busy      <= ~w_cs;
    end
  end

  // Select the byte currently being shifted out
  always_comb begin
    w_tx_byte = 8'h00;
    unique case (r_state)
      StData: w_tx_byte = r_mem_rdata;
      StStat: w_tx_byte = STATUS;
      StId: begin
        unique case (r_id_idx)
          2'd0:    w_tx_byte = 8'hEF;
          2'd1:    w_tx_byte = 8'h40;
          default: w_tx_byte = 8'h15;
        endcase
      end
      default: w_tx_byte = 8'h00;
    endcase
  end

  // Next-state logic: command decode, address capture, serial output
  always_comb begin
    w_state_next     = r_state;
    w_bit_cnt_next   = r_bit_cnt;
    w_cmd_shift_next = r_cmd_shift;
    w_addr_next      = r_addr;
    w_id_idx_next    = r_id_idx;
    w_miso_next      = r_miso;
    w_cmd_valid_next = 1'b0;
    w_cmd_code_next  = r_cmd_code;
    w_byte           = {r_cmd_shift, w_mosi};
    w_fetch          = 1'b0;
    w_fetch_addr     = r_addr;

    if (w_cs_rise) begin
      // Deselect aborts everything, including a partially shifted command
      w_state_next     = StIdle;
      w_bit_cnt_next   = 5'd0;
      w_cmd_shift_next = 7'd0;
      w_id_idx_next    = 2'd0;
      w_miso_next      = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_miso_next = 1'b0;
          if (w_cs_fall) begin
            w_state_next   = StCmd;
            w_bit_cnt_next = 5'd0;
          end
        end

        StCmd: begin
          if (w_rise) begin
            w_cmd_shift_next = w_byte[6:0];
            w_bit_cnt_next   = r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd7) begin
              w_bit_cnt_next   = 5'd0;
              w_cmd_valid_next = 1'b1;
              w_cmd_code_next  = w_byte;
              w_id_idx_next    = 2'd0;
              unique case (w_byte)
                8'h03:   w_state_next = StAddr;
                8'h9F:   w_state_next = StId;
                8'h05:   w_state_next = StStat;
                default: w_state_next = StIgnore;
              endcase
            end
          end
        end

        StAddr: begin
          if (w_rise) begin
            // Only the low AW bits survive the 24-bit shift
            w_addr_next    = {r_addr[AW-2:0], w_mosi};
            w_bit_cnt_next = r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd23) begin
              w_bit_cnt_next = 5'd0;
              w_fetch        = 1'b1;
              w_fetch_addr   = w_addr_next;
              w_state_next   = StData;
            end
          end
        end

        StData, StId, StStat: begin
          if (w_fall) begin
            w_miso_next    = w_tx_byte[3'd7 - r_bit_cnt[2:0]];
            w_bit_cnt_next = r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd7) begin
              w_bit_cnt_next = 5'd0;
              if (r_state == StData) begin
                // Prefetch the next byte; address wraps modulo DEPTH
                w_addr_next  = r_addr + {{(AW - 1) {1'b0}}, 1'b1};
                w_fetch      = 1'b1;
                w_fetch_addr = w_addr_next;
              end else if (r_state == StId) begin
                w_id_idx_next = (r_id_idx == 2'd2) ? 2'd0 : r_id_idx + 2'd1;
              end
            end
          end
        end

        StIgnore: w_miso_next = 1'b0;

        default: w_state_next = StIdle;
      endcase
    end
  end

  // Load port write and registered fetch; a same-cycle collision reads old data
  always_ff @(posedge i_clk) begin
    if (i_ld_en) begin
      r_mem[i_ld_addr] <= i_ld_data;
    end
    if (w_fetch) begin
      r_mem_rdata <= r_mem[w_fetch_addr];
    end
  end

  assign o_spi_miso  = r_miso;
  assign o_cmd_valid = r_cmd_valid;
  assign o_cmd_code  = r_cmd_code;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: the stimulus side queues expected
// command codes and response bytes, a monitor pops and compares them.
`timescale 1ns / 1ps

module tb_spi_flash_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       cs = 1'b1;
  logic       mosi = 1'b0;
  logic       ld_en = 1'b0;
  logic [7:0] ld_addr = 8'h00;
  logic [7:0] ld_data = 8'h00;
  logic       miso;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_cmd_q [$];
  logic [7:0] exp_rx_q  [$];
  logic [7:0] act_rx_q  [$];

  spi_flash_responder #(
    .DEPTH (256),
    .AW    (8),
    .STATUS(8'h00)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_spi_clk  (sclk),
    .i_cs       (cs),
    .i_spi_mosi (mosi),
    .o_spi_miso (miso),
    .i_ld_en    (ld_en),
    .i_ld_addr  (ld_addr),
    .i_ld_data  (ld_data),
    .o_cmd_valid(cmd_valid),
    .o_cmd_code (cmd_code),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every cmd_valid pulse and every received miso byte
  always @(negedge clk) begin
    if (!rst && cmd_valid) begin
      if (exp_cmd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cmd_valid: got pulse with code %h expected no pulse", cmd_code);
      end else begin
        chk("cmd_code", cmd_code, exp_cmd_q.pop_front());
      end
    end
    while (act_rx_q.size() > 0) begin
      if (exp_rx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL miso_byte: got %h expected nothing", act_rx_q.pop_front());
      end else begin
        chk("miso_byte", act_rx_q.pop_front(), exp_rx_q.pop_front());
      end
    end
  end

  // One SPI mode-0 bit: miso sampled just before the rising edge
  task automatic spi_bit(input logic b, output logic r);
    mosi = b;
    #80;
    r = miso;
    sclk = 1'b1;
    #80;
    sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, input logic [7:0] exp);
    logic [7:0] rx;
    logic       r;
    exp_rx_q.push_back(exp);
    for (int i = 0; i < 8; i++) begin
      spi_bit(tx[7-i], r);
      rx[7-i] = r;
    end
    act_rx_q.push_back(rx);
  endtask

  task automatic cs_low();
    cs = 1'b0;
    #80;
  endtask

  task automatic cs_high();
    #80;
    cs = 1'b1;
    #300;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic r;

    // Reset values
    repeat (3) @(negedge clk);
    chk("reset_miso", {7'd0, miso}, 8'h00);
    chk("reset_cmd_valid", {7'd0, cmd_valid}, 8'h00);
    chk("reset_cmd_code", cmd_code, 8'h00);
    chk("reset_busy", {7'd0, busy}, 8'h00);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    load(8'hFE, 8'hA5);
    load(8'hFF, 8'h3C);
    load(8'h00, 8'h81);
    load(8'h05, 8'h77);

    // JEDEC ID, including the repeat back to 0xEF
    exp_cmd_q.push_back(8'h9F);
    cs_low();
    spi_byte(8'h9F, 8'h00);
    chk("busy_active", {7'd0, busy}, 8'h01);
    spi_byte(8'h00, 8'hEF);
    spi_byte(8'h00, 8'h40);
    spi_byte(8'h00, 8'h15);
    spi_byte(8'h00, 8'hEF);
    cs_high();
    chk("busy_idle", {7'd0, busy}, 8'h00);
    chk("miso_idle", {7'd0, miso}, 8'h00);

    // Read with address wrap 0xFF -> 0x00
    exp_cmd_q.push_back(8'h03);
    cs_low();
    spi_byte(8'h03, 8'h00);
    spi_byte(8'h00, 8'h00);
    spi_byte(8'h00, 8'h00);
    spi_byte(8'hFE, 8'h00);
    spi_byte(8'h00, 8'hA5);
    spi_byte(8'h00, 8'h3C);
    spi_byte(8'h00, 8'h81);
    cs_high();

    // Upper address bits ignored
    exp_cmd_q.push_back(8'h03);
    cs_low();
    spi_byte(8'h03, 8'h00);
    spi_byte(8'h12, 8'h00);
    spi_byte(8'h34, 8'h00);
    spi_byte(8'h05, 8'h00);
    spi_byte(8'h00, 8'h77);
    cs_high();

    // Status register
    exp_cmd_q.push_back(8'h05);
    cs_low();
    spi_byte(8'h05, 8'h00);
    spi_byte(8'hFF, 8'h00);
    spi_byte(8'hFF, 8'h00);
    cs_high();

    // Unknown command
    exp_cmd_q.push_back(8'hAB);
    cs_low();
    spi_byte(8'hAB, 8'h00);
    spi_byte(8'hFF, 8'h00);
    spi_byte(8'hFF, 8'h00);
    cs_high();
    chk("cmd_code_held", cmd_code, 8'hAB);

    // Abort after 5 command bits: no pulse, code unchanged
    cs_low();
    for (int i = 0; i < 5; i++) spi_bit(1'b1, r);
    cs_high();
    chk("cmd_code_after_abort", cmd_code, 8'hAB);
    exp_cmd_q.push_back(8'h9F);
    cs_low();
    spi_byte(8'h9F, 8'h00);
    spi_byte(8'h00, 8'hEF);
    cs_high();

    // Reset in the middle of a DATA byte (0xA5 = 1010_0101)
    exp_cmd_q.push_back(8'h03);
    cs_low();
    spi_byte(8'h03, 8'h00);
    spi_byte(8'h00, 8'h00);
    spi_byte(8'h00, 8'h00);
    spi_byte(8'hFE, 8'h00);
    spi_bit(1'b0, r);
    chk("data_bit7", {7'd0, r}, 8'h01);
    spi_bit(1'b0, r);
    chk("data_bit6", {7'd0, r}, 8'h00);
    #60;
    chk("miso_before_rst", {7'd0, miso}, 8'h01);
    rst = 1'b1;
    #1;
    chk("rst_miso", {7'd0, miso}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_cmd_code", cmd_code, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cs_high();
    exp_cmd_q.push_back(8'h9F);
    cs_low();
    spi_byte(8'h9F, 8'h00);
    spi_byte(8'h00, 8'hEF);
    cs_high();

    repeat (5) @(negedge clk);
    chk("cmd_q_drained", 8'(exp_cmd_q.size()), 8'h00);
    chk("rx_q_drained", 8'(exp_rx_q.size()), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

SPI mode-0 target that emulates the read side of a W25Q16 serial flash: it answers JEDEC-ID, read-status and read-data commands from an SPI initiator out of a small internal byte memory. It serves as a bench/loopback partner for the team's SPI flash initiator, and as an on-chip stand-in for the flash when the physical part is absent. A system-side load port fills the memory.

## Interface
- DEPTH, 256: memory size in bytes; must be a power of two.
- AW, 8: memory address width, log2(DEPTH).
- STATUS, 8'h00: byte returned by command 0x05.
- clk  input  1  system clock; must be at least 12x the spi_clk frequency.
- rst  input  1  asynchronous, active-high reset.
- spi_clk  input  1  SPI clock from the initiator, asynchronous to clk.
- cs  input  1  chip select, active low, asynchronous.
- spi_mosi  input  1  serial data from the initiator.
- spi_miso  output  1  serial data to the initiator; driven at all times, never tri-stated.
- ld_en  input  1  write strobe for the load port.
- ld_addr  input  AW  load address.
- ld_data  input  8  load data.
- cmd_valid  output  1  one-clk pulse when a command byte completes.
- cmd_code  output  8  last command byte received; held until the next one.
- busy  output  1  high while a transaction is in progress (synced cs low).

## Operation
- spi_clk, cs and spi_mosi each pass through a 2-flop synchronizer.
- Rising and falling edges are detected on the synced spi_clk.
- spi_mosi is sampled on synced spi_clk rising edges, MSB first.
- spi_miso is updated on synced spi_clk falling edges, MSB first.
- FSM states:
  - IDLE: wait for synced cs falling.
  - CMD: shift 8 bits. On the 8th rising edge, pulse cmd_valid, latch cmd_code, then decode:
    - 0x03 -> ADDR
    - 0x9F -> ID
    - 0x05 -> STAT
    - anything else -> IGNORE
  - ADDR: shift 24 address bits. Only the low AW bits are kept; upper bits are ignored. After the 24th rising edge, fetch mem[addr] and go to DATA.
  - DATA: shift out the fetched byte. After the 8th bit, fetch the next byte, with addr incremented modulo DEPTH (DEPTH-1 wraps to 0). Continues indefinitely.
  - ID: output 0xEF, 0x40, 0x15, then repeat from 0xEF.
  - STAT: output STATUS repeatedly.
  - IGNORE: spi_miso held 0 until cs deasserts.
- Synced cs rising in any state:
  - go to IDLE, spi_miso = 0, bit counter cleared, partial bytes discarded.
  - a partial command byte produces no cmd_valid.
- Load port:
  - ld_en writes mem[ld_addr] = ld_data on the clk edge; accepted in any state.
  - a write and a fetch of the same address in the same cycle returns the old data.
- Memory contents are not cleared by rst.
- Reset mid-transaction: the state machine returns to IDLE with all outputs at reset values. A command is recognized only after a subsequent synced cs falling edge.

## Timing
- Reset values:
  - spi_miso = 0, cmd_valid = 0, cmd_code = 8'h00, busy = 0.
  - state IDLE, bit counter 0, address 0.
- Pin-to-internal latency: 2 clk (synchronizer) + 1 clk (edge detect).
- spi_miso changes exactly 1 clk after the internal falling-edge detect, so at most 4 clk after the pin edge.
- First output bit: bit 7 of the response is driven on the falling edge that follows the last input bit's rising edge (the 8th edge for ID/STAT, the 32nd for read). Each later bit follows on each later falling edge.
- Memory fetch: registered read, 1 clk. It completes before the next falling edge, given the ≥12x clock-ratio constraint.
- cmd_valid: asserts 1 clk after the internal rising-edge detect of bit 0 (the 8th bit), for exactly 1 clk.
- busy: follows synced cs with 1 clk latency.

## Test plan
- JEDEC ID: cs low, send 0x9F, clock 24 more bits -> miso carries 0xEF, 0x40, 0x15; cmd_valid pulses once; cmd_code = 0x9F.
- Read with wrap: load mem[0xFE] = 0xA5, mem[0xFF] = 0x3C, mem[0x00] = 0x81. Send 0x03, 0x00, 0x00, 0xFE, then clock 24 bits -> miso bytes 0xA5, 0x3C, 0x81.
- Upper address ignored: send 0x03, 0x12, 0x34, 0x05 with mem[0x05] = 0x77 -> first byte 0x77.
- Status and unknown command:
  - 0x05 with STATUS = 8'h00 -> miso stays 0x00 for 16 bits.
  - 0xAB -> miso held 0, cmd_code = 0xAB.
- Abort: cs high after 5 bits of a command -> no cmd_valid. A following 0x9F transaction returns 0xEF normally.
- Reset mid-read: assert rst during a DATA byte -> spi_miso = 0 and busy = 0 immediately. After release, a fresh cs cycle with 0x9F returns 0xEF.
